// File: rtl/mem_access_stage_pkg.sv
// mem_pkg: shared types and helpers for the MEM stage
// funct3 access encodings, FSM states, byte-strobe bases and the alignment check.
package mem_pkg;
  typedef enum logic [2:0] {F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU, F3_DX} funct3_e;
  typedef enum logic {IDLE, ACCESS} state_e;
  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;
  function automatic logic [7:0] strb_base(input logic [1:0] sz);
    return sz == 2'd0 ? STRB_B : sz == 2'd1 ? STRB_H : sz == 2'd2 ? STRB_W : STRB_D;
  endfunction
  // An access is aligned when the address bits below its size are zero.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] a);
    return (a & 3'((4'd1 << sz) - 4'd1)) == 3'd0;
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack port
// master (stage): req, we, addr, wdata, wstrb out; ack, rdata in. slave is the memory side.
interface mem_access_stage_if #(parameter int W = 64);
  logic           req;
  logic           we;
  logic [W-1:0]   addr;
  logic [W-1:0]   wdata;
  logic [W/8-1:0] wstrb;
  logic           ack;
  logic [W-1:0]   rdata;
  modport master(output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave(input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: extracts the addressed lane from a read doubleword and extends it
// rdata_i read data, off_i byte offset, funct3_i size/sign, data_o extended load value.
module load_align
  import mem_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] rdata_i,
  input  logic [2:0]   off_i,
  input  logic [2:0]   funct3_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};
  always_comb
    data_o = funct3_i == F3_B  ? {{(W-8){sh[7]}}, sh[7:0]} :
             funct3_i == F3_H  ? {{(W-16){sh[15]}}, sh[15:0]} :
             funct3_i == F3_W  ? {{(W-32){sh[31]}}, sh[31:0]} :
             funct3_i == F3_BU ? {{(W-8){1'b0}}, sh[7:0]} :
             funct3_i == F3_HU ? {{(W-16){1'b0}}, sh[15:0]} :
             funct3_i == F3_WU ? {{(W-32){1'b0}}, sh[31:0]} : sh;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with req/ack data-memory port and watchdog
// Inputs: EX/MEM entry (in_*), flush. Outputs: stall_out, dmem master port, MEM/WB bundle (out_*).
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic                      in_mem_or_reg,
  input  logic                      in_reg_write,
  input  logic [2:0]                in_funct3,
  input  logic [BUS_DATA_WIDTH-1:0] in_result,
  input  logic [BUS_DATA_WIDTH-1:0] in_store_data,
  input  logic [4:0]                in_dest_reg,
  input  logic                      flush,
  output logic                      stall_out,
  mem_access_stage_if.master        dmem,
  output logic                      out_valid,
  output logic                      out_reg_write,
  output logic                      out_mem_or_reg,
  output logic [4:0]                out_dest_reg,
  output logic [BUS_DATA_WIDTH-1:0] out_alu_result,
  output logic [BUS_DATA_WIDTH-1:0] out_load_data,
  output logic                      out_misaligned,
  output logic                      out_bus_err
);
  localparam int W = BUS_DATA_WIDTH;
  localparam int SB = W / 8;
  state_e        state_q;
  logic [15:0]   cnt_q;
  logic          req_q, we_q, rw_q, mor_q;
  logic [W-1:0]  addr_q, wdata_q;
  logic [SB-1:0] wstrb_q;
  logic [2:0]    f3_q;
  logic [4:0]    dest_q;
  logic          ov_q, orw_q, omor_q, omis_q, obe_q;
  logic [4:0]    odest_q;
  logic [W-1:0]  oalu_q, old_q;
  logic          accept, mem_op, aligned, timeout;
  logic [W-1:0]  wdata_d, ld_data;
  logic [SB-1:0] wstrb_d;
  assign accept    = in_valid & ~flush & (state_q == IDLE);
  assign mem_op    = in_mem_read | in_mem_write;
  assign aligned   = is_aligned(in_funct3[1:0], in_result[2:0]);
  assign wdata_d   = in_store_data << {in_result[2:0], 3'b000};
  // A read takes priority over a simultaneous write, so no strobes are latched for it.
  assign wstrb_d   = in_mem_read ? '0 : SB'(strb_base(in_funct3[1:0])) << in_result[2:0];
  assign timeout   = cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign stall_out = (state_q == ACCESS) | (accept & mem_op & aligned);
  load_align #(.W(W)) u_align (
    .rdata_i (dmem.rdata),
    .off_i   (addr_q[2:0]),
    .funct3_i(f3_q),
    .data_o  (ld_data)
  );
  assign dmem.req       = req_q;
  assign dmem.we        = we_q;
  assign dmem.addr      = {addr_q[W-1:3], 3'b000};
  assign dmem.wdata     = wdata_q;
  assign dmem.wstrb     = wstrb_q;
  assign out_valid      = ov_q;
  assign out_reg_write  = orw_q;
  assign out_mem_or_reg = omor_q;
  assign out_dest_reg   = odest_q;
  assign out_alu_result = oalu_q;
  assign out_load_data  = old_q;
  assign out_misaligned = omis_q;
  assign out_bus_err    = obe_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
      mor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      dest_q  <= '0;
      ov_q    <= 1'b0;
      orw_q   <= 1'b0;
      omor_q  <= 1'b0;
      omis_q  <= 1'b0;
      obe_q   <= 1'b0;
      odest_q <= '0;
      oalu_q  <= '0;
      old_q   <= '0;
    end else begin
      ov_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept & mem_op & aligned) begin
          state_q <= ACCESS;
          cnt_q   <= '0;
          req_q   <= 1'b1;
          we_q    <= in_mem_write & ~in_mem_read;
          rw_q    <= in_reg_write;
          mor_q   <= in_mem_or_reg;
          addr_q  <= in_result;
          wdata_q <= wdata_d;
          wstrb_q <= wstrb_d;
          f3_q    <= in_funct3;
          dest_q  <= in_dest_reg;
        end else if (accept) begin
          // Non-memory op passes straight through; a misaligned access retires flagged with no write-back.
          ov_q    <= 1'b1;
          orw_q   <= in_reg_write & ~mem_op;
          omor_q  <= in_mem_or_reg;
          odest_q <= in_dest_reg;
          oalu_q  <= in_result;
          old_q   <= '0;
          omis_q  <= mem_op;
          obe_q   <= 1'b0;
        end
      end else if (dmem.ack | timeout) begin
        // Ack wins over a coincident timeout.
        state_q <= IDLE;
        req_q   <= 1'b0;
        ov_q    <= 1'b1;
        orw_q   <= rw_q & dmem.ack;
        omor_q  <= mor_q;
        odest_q <= dest_q;
        oalu_q  <= addr_q;
        old_q   <= (dmem.ack & ~we_q) ? ld_data : '0;
        omis_q  <= 1'b0;
        obe_q   <= ~dmem.ack;
      end else
        cnt_q <= cnt_q + 16'd1;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  typedef struct packed {
    logic        rw;
    logic        mor;
    logic [4:0]  dest;
    logic [63:0] alu;
    logic [63:0] ld;
    logic        mis;
    logic        be;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mem_read, in_mem_write, in_mem_or_reg, in_reg_write, flush;
  logic [2:0]  in_funct3;
  logic [63:0] in_result, in_store_data;
  logic [4:0]  in_dest_reg;
  logic        stall_out, out_valid, out_reg_write, out_mem_or_reg, out_misaligned, out_bus_err;
  logic [4:0]  out_dest_reg;
  logic [63:0] out_alu_result, out_load_data;
  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_pass = 0;
  mem_access_stage_if #(.W(64)) dmem ();
  mem_access_stage #(.BUS_DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_or_reg(in_mem_or_reg), .in_reg_write(in_reg_write),
    .in_funct3(in_funct3), .in_result(in_result), .in_store_data(in_store_data),
    .in_dest_reg(in_dest_reg), .flush(flush), .stall_out(stall_out), .dmem(dmem),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_or_reg(out_mem_or_reg),
    .out_dest_reg(out_dest_reg), .out_alu_result(out_alu_result), .out_load_data(out_load_data),
    .out_misaligned(out_misaligned), .out_bus_err(out_bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endtask
  function automatic exp_t mk(input logic rw, input logic mor, input logic [4:0] d,
                              input logic [63:0] a, input logic [63:0] l, input logic mi, input logic b);
    exp_t r;
    r.rw = rw; r.mor = mor; r.dest = d; r.alu = a; r.ld = l; r.mis = mi; r.be = b;
    return r;
  endfunction
  always @(negedge clk)
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: out_valid=1 with empty scoreboard, alu=%h", out_alu_result);
      end else begin
        e = q.pop_front();
        chk("sb_reg_write", out_reg_write, e.rw);
        chk("sb_mem_or_reg", out_mem_or_reg, e.mor);
        chk("sb_dest", out_dest_reg, e.dest);
        chk("sb_alu", out_alu_result, e.alu);
        chk("sb_load", out_load_data, e.ld);
        chk("sb_misaligned", out_misaligned, e.mis);
        chk("sb_bus_err", out_bus_err, e.be);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_mem_or_reg = 0; in_reg_write = 0;
    in_funct3 = 0; in_result = 0; in_store_data = 0; in_dest_reg = 0; flush = 0;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic mor, input logic rw,
                       input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd, input logic [4:0] d);
    in_valid = 1; in_mem_read = rd; in_mem_write = wr; in_mem_or_reg = mor; in_reg_write = rw;
    in_funct3 = f3; in_result = a; in_store_data = sd; in_dest_reg = d; flush = 0;
  endtask
  task automatic mem_op(input logic rd, input logic wr, input logic mor, input logic rw,
                        input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd,
                        input logic [4:0] d, input logic [63:0] rdv, input int waits,
                        input logic [63:0] e_addr, input logic [63:0] e_wdata,
                        input logic [7:0] e_strb, input logic [63:0] e_ld);
    step();
    drive(rd, wr, mor, rw, f3, a, sd, d);
    q.push_back(mk(rw, mor, d, a, e_ld, 1'b0, 1'b0));
    @(negedge clk);
    chk("stall_accept", stall_out, 1);
    step();
    idle_in();
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("req_wait", dmem.req, 1);
      chk("stall_wait", stall_out, 1);
      step();
    end
    dmem.ack = 1;
    dmem.rdata = rdv;
    @(negedge clk);
    chk("req_ack", dmem.req, 1);
    chk("we", dmem.we, wr & ~rd);
    chk("addr", dmem.addr, e_addr);
    chk("wdata", dmem.wdata, e_wdata);
    chk("wstrb", dmem.wstrb, e_strb);
    step();
    dmem.ack = 0;
    dmem.rdata = 0;
    @(negedge clk);
    chk("req_drop", dmem.req, 0);
    chk("valid_after_ack", out_valid, 1);
    chk("stall_release", stall_out, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    reset_n = 0;
    idle_in();
    dmem.ack = 0;
    dmem.rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_req", dmem.req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_alu", out_alu_result, 0);
    chk("rst_wstrb", dmem.wstrb, 0);
    step();
    reset_n = 1;
    // ADD: pass-through
    step();
    drive(0, 0, 0, 1, 3'd0, 64'h1234, 64'h0, 5'd5);
    q.push_back(mk(1, 0, 5, 64'h1234, 0, 0, 0));
    @(negedge clk);
    chk("add_stall", stall_out, 0);
    step();
    idle_in();
    @(negedge clk);
    chk("add_no_req", dmem.req, 0);
    chk("add_valid", out_valid, 1);
    // Stores
    mem_op(0, 1, 0, 0, 3'd0, 64'h1003, 64'hAB, 5'd0, 0, 0, 64'h1000, 64'hAB00_0000, 8'h08, 0);
    mem_op(0, 1, 0, 0, 3'd1, 64'h6002, 64'h1111_2222_3333_BEEF, 5'd0, 0, 1,
           64'h6000, 64'h2222_3333_BEEF_0000, 8'h0C, 0);
    mem_op(0, 1, 0, 0, 3'd3, 64'h6008, 64'h0102_0304_0506_0708, 5'd0, 0, 0,
           64'h6008, 64'h0102_0304_0506_0708, 8'hFF, 0);
    // Loads; three waits with a 4-cycle watchdog puts ack on the final cycle
    mem_op(1, 0, 1, 1, 3'd0, 64'h2001, 0, 5'd7, 64'h8000, 3, 64'h2000, 0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op(1, 0, 1, 1, 3'd4, 64'h2001, 0, 5'd7, 64'h8000, 3, 64'h2000, 0, 8'h00, 64'h80);
    mem_op(1, 0, 1, 1, 3'd1, 64'h4006, 0, 5'd8, 64'h1234_5678_9ABC_DEF0, 0, 64'h4000, 0, 8'h00, 64'h1234);
    mem_op(1, 1, 1, 1, 3'd2, 64'h5004, 0, 5'd9, 64'h8765_4321_0000_0000, 1, 64'h5000, 0, 8'h00,
           64'hFFFF_FFFF_8765_4321);
    mem_op(1, 0, 1, 1, 3'd6, 64'h5004, 0, 5'd9, 64'h8765_4321_0000_0000, 0, 64'h5000, 0, 8'h00,
           64'h8765_4321);
    mem_op(1, 0, 1, 1, 3'd7, 64'h8000, 0, 5'd10, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h8000, 0, 8'h00,
           64'hDEAD_BEEF_CAFE_F00D);
    // Misaligned LW
    step();
    drive(1, 0, 1, 1, 3'd2, 64'h3002, 0, 5'd11);
    q.push_back(mk(0, 1, 11, 64'h3002, 0, 1, 0));
    @(negedge clk);
    chk("mis_stall", stall_out, 0);
    step();
    idle_in();
    @(negedge clk);
    chk("mis_no_req", dmem.req, 0);
    chk("mis_valid", out_valid, 1);
    // Watchdog abort
    step();
    drive(1, 0, 1, 1, 3'd3, 64'h7000, 0, 5'd9);
    q.push_back(mk(0, 1, 9, 64'h7000, 0, 0, 1));
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req_high", dmem.req, 1);
      step();
    end
    @(negedge clk);
    chk("to_req_drop", dmem.req, 0);
    chk("to_valid", out_valid, 1);
    chk("to_stall", stall_out, 0);
    step();
    drive(0, 0, 0, 1, 3'd0, 64'h55, 0, 5'd6);
    q.push_back(mk(1, 0, 6, 64'h55, 0, 0, 0));
    step();
    idle_in();
    @(negedge clk);
    chk("to_next_valid", out_valid, 1);
    // Flush in IDLE kills the entry
    step();
    drive(0, 0, 0, 1, 3'd0, 64'h99, 0, 5'd4);
    flush = 1;
    @(negedge clk);
    chk("flush_idle_stall", stall_out, 0);
    step();
    idle_in();
    @(negedge clk);
    chk("flush_idle_valid", out_valid, 0);
    // Flush during ACCESS leaves the load completing
    step();
    drive(1, 0, 1, 1, 3'd4, 64'hA005, 0, 5'd12);
    q.push_back(mk(1, 1, 12, 64'hA005, 64'h5A, 0, 0));
    step();
    drive(0, 0, 0, 1, 3'd0, 64'hBAD, 0, 5'd13);
    flush = 1;
    @(negedge clk);
    chk("flush_acc_req", dmem.req, 1);
    step();
    dmem.ack = 1;
    dmem.rdata = 64'h0000_5A00_0000_0000;
    @(negedge clk);
    chk("flush_acc_req2", dmem.req, 1);
    step();
    dmem.ack = 0;
    dmem.rdata = 0;
    idle_in();
    @(negedge clk);
    chk("flush_acc_valid", out_valid, 1);
    // Reset in the middle of an access
    step();
    drive(1, 0, 1, 1, 3'd3, 64'h9000, 0, 5'd14);
    step();
    idle_in();
    @(negedge clk);
    chk("rst_mid_req_before", dmem.req, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_req", dmem.req, 0);
    chk("rst_mid_stall", stall_out, 0);
    chk("rst_mid_alu", out_alu_result, 0);
    chk("rst_mid_dest", out_dest_reg, 0);
    step();
    reset_n = 1;
    repeat (3) step();
    drive(0, 0, 0, 1, 3'd0, 64'h77, 0, 5'd3);
    q.push_back(mk(1, 0, 3, 64'h77, 0, 0, 0));
    step();
    idle_in();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    repeat (3) step();
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
